// File: rtl/fsm_trace_checker_pkg.sv
// Shared types and default sizes for the FSM trace checker.
// Holds the control-state enum and the state-count derivation used by every file.
package fsm_trace_pkg;

  localparam int STATE_W_DEFAULT = 3;
  localparam int CNT_W_DEFAULT   = 16;

  typedef enum logic [1:0] {
    CTL_IDLE  = 2'd0,
    CTL_PRIME = 2'd1,
    CTL_RUN   = 2'd2
  } ctl_state_e;

  function automatic int nstates(input int state_w);
    return 1 << state_w;
  endfunction

endpackage

// File: rtl/fsm_trace_checker_if.sv
// Signal bundle between the monitored-FSM side (master) and the trace checker (slave).
interface fsm_trace_checker_if
  import fsm_trace_pkg::*;
#(
  parameter int STATE_W = STATE_W_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
);
  localparam int NSTATES = nstates(STATE_W);

  logic [STATE_W-1:0] q;
  logic               en;
  logic               clr;
  logic               cfg_we;
  logic [STATE_W-1:0] cfg_row;
  logic [NSTATES-1:0] cfg_mask;
  logic [STATE_W-1:0] hist_sel;

  logic               err_pulse;
  logic               err_sticky;
  logic [STATE_W-1:0] err_from;
  logic [STATE_W-1:0] err_to;
  logic [CNT_W-1:0]   trans_cnt;
  logic               stuck;
  logic [CNT_W-1:0]   hist_cnt;

  modport master (
    output q, en, clr, cfg_we, cfg_row, cfg_mask, hist_sel,
    input  err_pulse, err_sticky, err_from, err_to, trans_cnt, stuck, hist_cnt
  );

  modport slave (
    input  q, en, clr, cfg_we, cfg_row, cfg_mask, hist_sel,
    output err_pulse, err_sticky, err_from, err_to, trans_cnt, stuck, hist_cnt
  );

endinterface

// File: rtl/fsm_trace_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// count_next is exposed so callers can register decisions on the upcoming value.
module fsm_trace_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);

  logic [W-1:0] count_reg;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != '1)) begin
      count_next = count_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fsm_trace_checker.sv
// Monitors a state code against a programmable legal-transition table.
// Optional per-state visit histogram is built only when FSM_TRACE_HIST_EN is defined.
module fsm_trace_checker
  import fsm_trace_pkg::*;
#(
  parameter int STATE_W   = STATE_W_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int STALL_MAX = 0
) (
  input logic               clk,
  input logic               reset,
  fsm_trace_checker_if.slave bus
);

  localparam int NSTATES = nstates(STATE_W);

  genvar gi;

  ctl_state_e         state_reg;
  ctl_state_e         state_next;
  logic               do_prime;
  logic               do_check;

  logic [STATE_W-1:0] prev_q_reg;
  logic [NSTATES-1:0] legal_reg [NSTATES];
  logic [NSTATES-1:0] row_legal;
  logic               changed;
  logic               step;
  logic               illegal;

  logic               err_pulse_reg;
  logic               err_sticky_reg;
  logic [STATE_W-1:0] err_from_reg;
  logic [STATE_W-1:0] err_to_reg;
  logic               stuck_reg;

  logic [CNT_W-1:0]   trans_cnt;
  logic [CNT_W-1:0]   unused_trans_next;
  logic [CNT_W-1:0]   unused_stall_cnt;
  logic [CNT_W-1:0]   stall_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CTL_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!bus.en) begin
      state_next = CTL_IDLE;
    end else begin
      case (state_reg)
        CTL_IDLE:  state_next = CTL_PRIME;
        CTL_PRIME: state_next = CTL_RUN;
        CTL_RUN:   state_next = CTL_RUN;
        default:   state_next = CTL_IDLE;
      endcase
    end
  end

  // Actions are qualified by en so a dropping enable never checks on its way to IDLE.
  always_comb begin
    do_prime = 1'b0;
    do_check = 1'b0;
    case (state_reg)
      CTL_PRIME: do_prime = bus.en;
      CTL_RUN:   do_check = bus.en;
      default:   ;
    endcase
  end

  assign changed   = (bus.q != prev_q_reg);
  assign row_legal = legal_reg[prev_q_reg];
  assign step      = do_check && changed;
  assign illegal   = step && !row_legal[bus.q];

  // Row writes land at the edge, so a same-cycle check still sees the old row.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSTATES; i++) begin
        legal_reg[i] <= '1;
      end
    end else if (bus.cfg_we) begin
      legal_reg[bus.cfg_row] <= bus.cfg_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q_reg <= '0;
    end else if (do_prime || do_check) begin
      prev_q_reg <= bus.q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      err_pulse_reg  <= 1'b0;
      err_sticky_reg <= 1'b0;
      err_from_reg   <= '0;
      err_to_reg     <= '0;
    end else begin
      err_pulse_reg <= illegal;
      if (illegal && !err_sticky_reg) begin
        err_sticky_reg <= 1'b1;
        err_from_reg   <= prev_q_reg;
        err_to_reg     <= bus.q;
      end
    end
  end

  fsm_trace_sat_cnt #(.W(CNT_W)) u_trans_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (bus.clr),
    .inc        (step),
    .count      (trans_cnt),
    .count_next (unused_trans_next)
  );

  fsm_trace_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (bus.clr || do_prime || step),
    .inc        (do_check && !changed),
    .count      (unused_stall_cnt),
    .count_next (stall_next)
  );

  // Registered from the counter's next value to keep stuck aligned with the sample that caused it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stuck_reg <= 1'b0;
    end else begin
      stuck_reg <= (STALL_MAX != 0) && (stall_next >= CNT_W'(STALL_MAX));
    end
  end

  assign bus.err_pulse  = err_pulse_reg;
  assign bus.err_sticky = err_sticky_reg;
  assign bus.err_from   = err_from_reg;
  assign bus.err_to     = err_to_reg;
  assign bus.trans_cnt  = trans_cnt;
  assign bus.stuck      = stuck_reg;

`ifdef FSM_TRACE_HIST_EN
  logic [CNT_W-1:0] hist_arr         [NSTATES];
  logic [CNT_W-1:0] unused_hist_next [NSTATES];

  generate
    for (gi = 0; gi < NSTATES; gi++) begin : g_hist
      fsm_trace_sat_cnt #(.W(CNT_W)) u_hist_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr        (bus.clr),
        .inc        ((do_prime || step) && (bus.q == STATE_W'(gi))),
        .count      (hist_arr[gi]),
        .count_next (unused_hist_next[gi])
      );
    end
  endgenerate

  assign bus.hist_cnt = hist_arr[bus.hist_sel];
`else
  logic unused_hist_sel;

  assign unused_hist_sel = ^bus.hist_sel;
  assign bus.hist_cnt    = '0;
`endif

endmodule

// File: tb/tb_fsm_trace_checker.sv
// Directed bench: each vector pushes its hand-computed expected outputs; a monitor pops and compares after the edge.
module tb_fsm_trace_checker;
  import fsm_trace_pkg::*;

  localparam int X = -1;
`ifdef FSM_TRACE_HIST_EN
  localparam int HE = 1;
`else
  localparam int HE = 0;
`endif

  typedef struct {
    string name;
    int    pulse;
    int    sticky;
    int    from;
    int    to;
    int    tcnt;
    int    stuck;
    int    hist;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_vec;
  int   n_miss;

  fsm_trace_checker_if #(.STATE_W(3), .CNT_W(16)) bus ();

  fsm_trace_checker #(.STATE_W(3), .CNT_W(16), .STALL_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string vname, input string field, input logic [31:0] act, input int exp_v);
    if (exp_v != X) begin
      if (act !== 32'(exp_v)) begin
        n_miss++;
        $display("FAIL %s.%s got %0d expected %0d", vname, field, act, exp_v);
      end
    end
  endtask

  // Monitor: outputs for vector k are checked just after the edge that samples it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        cmp(e.name, "err_pulse",  32'(bus.err_pulse),  e.pulse);
        cmp(e.name, "err_sticky", 32'(bus.err_sticky), e.sticky);
        cmp(e.name, "err_from",   32'(bus.err_from),   e.from);
        cmp(e.name, "err_to",     32'(bus.err_to),     e.to);
        cmp(e.name, "trans_cnt",  32'(bus.trans_cnt),  e.tcnt);
        cmp(e.name, "stuck",      32'(bus.stuck),      e.stuck);
        cmp(e.name, "hist_cnt",   32'(bus.hist_cnt),   e.hist);
        $display("vec %-12s q=%0d pulse=%0d sticky=%0d from=%0d to=%0d tcnt=%0d stuck=%0d hist=%0d",
                 e.name, bus.q, bus.err_pulse, bus.err_sticky, bus.err_from, bus.err_to,
                 bus.trans_cnt, bus.stuck, bus.hist_cnt);
      end
    end
  end

  task automatic step(input string name, input logic r, input logic e, input logic c, input int qv,
                      input logic we, input int row, input int mask, input int hsel,
                      input int p, input int s, input int f, input int t,
                      input int tc, input int st, input int h);
    exp_t x;
    @(negedge clk);
    reset        = r;
    bus.en       = e;
    bus.clr      = c;
    bus.q        = 3'(qv);
    bus.cfg_we   = we;
    bus.cfg_row  = 3'(row);
    bus.cfg_mask = 8'(mask);
    bus.hist_sel = 3'(hsel);
    x.name = name; x.pulse = p; x.sticky = s; x.from = f; x.to = t;
    x.tcnt = tc; x.stuck = st; x.hist = h;
    sb.push_back(x);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    reset = 1'b1;
    bus.en = 1'b0; bus.clr = 1'b0; bus.q = '0; bus.cfg_we = 1'b0;
    bus.cfg_row = '0; bus.cfg_mask = '0; bus.hist_sel = '0;

    // name          rst en clr q  we row mask  hsel | pulse sticky from to tcnt stuck hist
    step("reset",      1, 0, 0, 0,  0, 0, 8'h00, 0,   0, 0, 0, 0, 0,  0, 0);
    step("en_on",      0, 1, 0, 0,  0, 0, 8'h00, 0,   0, 0, 0, 0, 0,  0, X);
    step("prime",      0, 1, 0, 0,  0, 0, 8'h00, 0,   0, 0, 0, 0, 0,  0, X);
    step("dflt_0to1",  0, 1, 0, 1,  0, 0, 8'h00, 0,   0, 0, X, X, 1,  0, X);
    step("dflt_1to2",  0, 1, 0, 2,  0, 0, 8'h00, 0,   0, 0, X, X, 2,  0, X);
    step("dflt_2to3",  0, 1, 0, 3,  0, 0, 8'h00, 0,   0, 0, 0, 0, 3,  0, X);
    // Restrict row 1 to only 1->2 while checking 3->1 on another row.
    step("cfg_row1",   0, 1, 0, 1,  1, 1, 8'h04, 0,   0, 0, X, X, 4,  0, X);
    step("ill_1to3",   0, 1, 0, 3,  0, 0, 8'h00, 0,   1, 1, 1, 3, 5,  0, X);
    step("ok_3to1",    0, 1, 0, 1,  0, 0, 8'h00, 0,   0, 1, 1, 3, 6,  0, X);
    step("ill_1to5",   0, 1, 0, 5,  0, 0, 8'h00, 0,   1, 1, 1, 3, 7,  0, X);
    // Stall: q holds at 5; stuck after the fourth equal sample.
    step("hold5_1",    0, 1, 0, 5,  0, 0, 8'h00, 0,   0, 1, 1, 3, 7,  0, X);
    step("hold5_2",    0, 1, 0, 5,  0, 0, 8'h00, 0,   0, 1, X, X, 7,  0, X);
    step("hold5_3",    0, 1, 0, 5,  0, 0, 8'h00, 0,   0, 1, X, X, 7,  0, X);
    step("hold5_4",    0, 1, 0, 5,  0, 0, 8'h00, 0,   0, 1, X, X, 7,  1, X);
    step("move_5to6",  0, 1, 0, 6,  0, 0, 8'h00, 0,   0, 1, X, X, 8,  0, X);
    // Same-cycle write of row 6 while checking 6->1 uses the old row.
    step("wr_row6",    0, 1, 0, 1,  1, 6, 8'h00, 0,   0, 1, 1, 3, 9,  0, X);
    step("ok_1to2",    0, 1, 0, 2,  0, 0, 8'h00, 0,   0, 1, X, X, 10, 0, X);
    step("ok_2to6",    0, 1, 0, 6,  0, 0, 8'h00, 0,   0, 1, X, X, 11, 0, X);
    step("ill_6to0",   0, 1, 0, 0,  0, 0, 8'h00, 0,   1, 1, 1, 3, 12, 0, X);
    // clr beats a simultaneous illegal 1->3.
    step("ok_0to1",    0, 1, 0, 1,  0, 0, 8'h00, 0,   0, 1, 1, 3, 13, 0, X);
    step("clr_ill",    0, 1, 1, 3,  0, 0, 8'h00, 0,   0, 0, 0, 0, 0,  0, X);
    step("after_clr",  0, 1, 0, 2,  0, 0, 8'h00, 0,   0, 0, 0, 0, 1,  0, X);
    step("ok_2to1",    0, 1, 0, 1,  0, 0, 8'h00, 0,   0, 0, 0, 0, 2,  0, X);
    step("ill2_1to3",  0, 1, 0, 3,  0, 0, 8'h00, 0,   1, 1, 1, 3, 3,  0, X);
    // Reset mid-run clears everything and restores an all-ones table.
    step("rst_run",    1, 1, 0, 3,  0, 0, 8'h00, 0,   0, 0, 0, 0, 0,  0, 0);
    step("re_en",      0, 1, 0, 1,  0, 0, 8'h00, 0,   0, 0, 0, 0, 0,  0, X);
    step("re_prime",   0, 1, 0, 1,  0, 0, 8'h00, 0,   0, 0, 0, 0, 0,  0, X);
    step("tbl_1to3",   0, 1, 0, 3,  0, 0, 8'h00, 0,   0, 0, 0, 0, 1,  0, X);
    // Histogram: PRIME at 0, then 0->2->0->2.
    step("h_reset",    1, 0, 0, 0,  0, 0, 8'h00, 0,   0, 0, 0, 0, 0,  0, 0);
    step("h_en",       0, 1, 0, 0,  0, 0, 8'h00, 0,   0, 0, 0, 0, 0,  0, 0);
    step("h_prime",    0, 1, 0, 0,  0, 0, 8'h00, 0,   0, 0, 0, 0, 0,  0, HE);
    step("h_0to2",     0, 1, 0, 2,  0, 0, 8'h00, 2,   0, 0, 0, 0, 1,  0, HE);
    step("h_2to0",     0, 1, 0, 0,  0, 0, 8'h00, 0,   0, 0, 0, 0, 2,  0, 2*HE);
    step("h_0to2b",    0, 1, 0, 2,  0, 0, 8'h00, 2,   0, 0, 0, 0, 3,  0, 2*HE);
    step("h_sel2",     0, 1, 0, 2,  0, 0, 8'h00, 2,   0, 0, 0, 0, 3,  0, 2*HE);
    step("h_sel0",     0, 1, 0, 2,  0, 0, 8'h00, 0,   0, 0, 0, 0, 3,  0, 2*HE);
    // Disabled: counters hold, nothing is checked in IDLE.
    step("dis_hold",   0, 0, 0, 2,  0, 0, 8'h00, 0,   0, 0, 0, 0, 3,  0, X);
    step("idle_q5",    0, 0, 0, 5,  0, 0, 8'h00, 5,   0, 0, 0, 0, 3,  0, 0);
    step("idle_q1",    0, 0, 0, 1,  0, 0, 8'h00, 0,   0, 0, 0, 0, 3,  0, 2*HE);

    for (int i = 0; i < 4 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
